// File: rtl/pc104_sig_pkg.sv
// Shared constants, offset codes and FSM encoding for the PC104 signal board.
package pc104_sig_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned IN_W   = 8;
  localparam int unsigned OFS_W  = 3;

  localparam logic [ADDR_W-1:0] BASE_ADDR_DEF = 12'h240;

  localparam logic [OFS_W-1:0] OFS_MODE   = 3'd0;
  localparam logic [OFS_W-1:0] OFS_LIVE   = 3'd3;
  localparam logic [OFS_W-1:0] OFS_STICKY = 3'd4;
  localparam logic [OFS_W-1:0] OFS_COUNT  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRIVE   = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  // True when an address offset from the base selects a readable register.
  function automatic logic ofs_hit(input logic [ADDR_W-1:0] ofs);
    logic hit;
    hit = 1'b0;
    if (ofs[ADDR_W-1:OFS_W] == '0) begin
      case (ofs[OFS_W-1:0])
        OFS_MODE, OFS_LIVE, OFS_STICKY, OFS_COUNT: hit = 1'b1;
        default:                                   hit = 1'b0;
      endcase
    end
    return hit;
  endfunction

endpackage

// File: rtl/pc104_sync2.sv
// Two-flop synchronizer with a synchronous reset value.
module pc104_sync2 #(
  parameter int unsigned   W       = 1,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Metastability stage followed by the output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pc104_status_read_responder.sv
// ISA IOR responder: mode readback, live inputs, sticky change flags, edge count.
module pc104_status_read_responder
  import pc104_sig_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IOR,
  input  logic [11:0] SA,
  input  logic [7:0]  IN_SD,
  input  logic [2:0]  MODE_RB,
  output logic [15:0] SD_OUT,
  output logic        SD_OE
);

  logic              ior_s;
  logic              ior_prev;
  logic [IN_W-1:0]   in_sync;
  logic [IN_W-1:0]   in_prev;
  logic [IN_W-1:0]   sticky_q;
  logic [IN_W-1:0]   sticky_clr;
  logic [CNT_W-1:0]  count_q;
  logic [OFS_W-1:0]  ofs_q;
  logic [OFS_W-1:0]  ofs_d;
  logic [ADDR_W-1:0] sa_ofs;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] sd_out_d;
  logic              sd_oe_d;
  logic              ior_fall;
  logic              cnt_inc;
  state_e            state_q;
  state_e            state_d;

  pc104_sync2 #(.W(1), .RST_VAL(1'b0)) u_sync_ior (
    .clk (CLK),
    .rst (RST),
    .d   (IOR),
    .q   (ior_s)
  );

  pc104_sync2 #(.W(IN_W), .RST_VAL(8'h00)) u_sync_in (
    .clk (CLK),
    .rst (RST),
    .d   (IN_SD),
    .q   (in_sync)
  );

  assign ior_fall = ior_prev & ~ior_s;
  assign sa_ofs   = ADDR_W'(SA - BASE_ADDR);
  assign cnt_inc  = in_sync[0] & ~in_prev[0];

  // Source select for the word snapshotted in CAPTURE.
  always_comb begin
    rd_word = '0;
    case (ofs_q)
      OFS_MODE:   rd_word = {13'b0, MODE_RB};
      OFS_LIVE:   rd_word = {8'b0, in_sync};
      OFS_STICKY: rd_word = {8'b0, sticky_q};
      OFS_COUNT:  rd_word = DATA_W'(count_q);
      default:    rd_word = '0;
    endcase
  end

  // Next-state and registered-output values for the read handshake.
  always_comb begin
    state_d    = state_q;
    ofs_d      = ofs_q;
    sd_out_d   = SD_OUT;
    sd_oe_d    = 1'b0;
    sticky_clr = '0;
    case (state_q)
      ST_IDLE: begin
        if (ior_fall && ofs_hit(sa_ofs)) begin
          state_d = ST_CAPTURE;
          ofs_d   = sa_ofs[OFS_W-1:0];
        end
      end
      ST_CAPTURE: begin
        state_d  = ST_DRIVE;
        sd_out_d = rd_word;
        sd_oe_d  = 1'b1;
      end
      ST_DRIVE: begin
        if (ior_s) state_d = ST_RELEASE;
        else       sd_oe_d = 1'b1;
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        // Only bits that were actually returned to the host are cleared.
        if (ofs_q == OFS_STICKY) sticky_clr = SD_OUT[IN_W-1:0];
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, offset latch and read-data output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      ofs_q   <= '0;
      SD_OUT  <= '0;
      SD_OE   <= 1'b0;
    end else begin
      state_q <= state_d;
      ofs_q   <= ofs_d;
      SD_OUT  <= sd_out_d;
      SD_OE   <= sd_oe_d;
    end
  end

  // Edge history, sticky change flags (set beats clear) and rising-edge counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ior_prev <= 1'b0;
      in_prev  <= '0;
      sticky_q <= '0;
      count_q  <= '0;
    end else begin
      ior_prev <= ior_s;
      in_prev  <= in_sync;
      sticky_q <= (sticky_q & ~sticky_clr) | (in_sync ^ in_prev);
      if (cnt_inc) count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc104_status_read_responder.sv
// Directed bench for the PC104 status read responder.
module tb_pc104_status_read_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IOR = 1'b0;
  logic [11:0] SA = 12'h243;
  logic [7:0]  IN_SD = 8'h00;
  logic [2:0]  MODE_RB = 3'b000;
  logic [15:0] SD_OUT;
  logic        SD_OE;

  int total = 0;
  int bad   = 0;

  pc104_status_read_responder dut (
    .CLK     (CLK),
    .RST     (RST),
    .IOR     (IOR),
    .SA      (SA),
    .IN_SD   (IN_SD),
    .MODE_RB (MODE_RB),
    .SD_OUT  (SD_OUT),
    .SD_OE   (SD_OE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One IOR cycle; fall_tog/rise_tog flip IN_SD one clock after IOR falls/rises.
  task automatic read_cycle(input logic [11:0] sa, input logic [15:0] exp, input logic exp_oe,
                            input logic [7:0] fall_tog, input logic [7:0] rise_tog, input string tag);
    @(negedge CLK); SA = sa; IOR = 1'b0;
    @(negedge CLK); IN_SD = IN_SD ^ fall_tog;
    @(negedge CLK);
    @(negedge CLK); check({tag, "_oe_early"}, 16'(SD_OE), 16'h0000);
    @(negedge CLK); check({tag, "_oe_on"}, 16'(SD_OE), 16'(exp_oe));
    if (exp_oe) check({tag, "_data"}, SD_OUT, exp);
    repeat (2) @(negedge CLK);
    if (exp_oe) check({tag, "_hold"}, SD_OUT, exp);
    IOR = 1'b1;
    @(negedge CLK); IN_SD = IN_SD ^ rise_tog;
    check({tag, "_oe_r1"}, 16'(SD_OE), 16'(exp_oe));
    @(negedge CLK); check({tag, "_oe_r2"}, 16'(SD_OE), 16'(exp_oe));
    @(negedge CLK); check({tag, "_oe_off"}, 16'(SD_OE), 16'h0000);
    if (exp_oe) check({tag, "_keep"}, SD_OUT, exp);
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    // 1: reset with IOR held low; no response until IOR is seen high
    repeat (3) @(negedge CLK);
    check("rst_oe", 16'(SD_OE), 16'h0000);
    check("rst_out", SD_OUT, 16'h0000);
    RST = 1'b0;
    repeat (6) @(negedge CLK);
    check("low_after_rst_oe", 16'(SD_OE), 16'h0000);
    IOR = 1'b1;
    repeat (4) @(negedge CLK);
    read_cycle(12'h243, 16'h0000, 1'b1, 8'h00, 8'h00, "first_live");

    // 2: live inputs
    IN_SD = 8'hA5;
    repeat (4) @(negedge CLK);
    read_cycle(12'h243, 16'h00A5, 1'b1, 8'h00, 8'h00, "live_a5");

    // 3: sticky flags, read-to-clear, set wins over clear in RELEASE
    read_cycle(12'h244, 16'h00A5, 1'b1, 8'h00, 8'h00, "sticky_flush");
    IN_SD = 8'h84;
    repeat (4) @(negedge CLK);
    read_cycle(12'h244, 16'h0021, 1'b1, 8'h00, 8'h00, "sticky_21");
    read_cycle(12'h244, 16'h0000, 1'b1, 8'h00, 8'h00, "sticky_clr");
    IN_SD = 8'hA4;
    repeat (4) @(negedge CLK);
    read_cycle(12'h244, 16'h0020, 1'b1, 8'h00, 8'h20, "sticky_rel_tog");
    read_cycle(12'h244, 16'h0020, 1'b1, 8'h00, 8'h00, "sticky_setwins");
    read_cycle(12'h244, 16'h0000, 1'b1, 8'h00, 8'h00, "sticky_empty");

    // 4: counter wrap and increment during CAPTURE
    @(negedge CLK); force dut.count_q = 16'hFFFE;
    @(negedge CLK); release dut.count_q;
    for (int i = 0; i < 3; i++) begin
      IN_SD[0] = 1'b1; repeat (3) @(negedge CLK);
      if (i < 2) begin IN_SD[0] = 1'b0; repeat (3) @(negedge CLK); end
    end
    repeat (2) @(negedge CLK);
    read_cycle(12'h245, 16'h0001, 1'b1, 8'h00, 8'h00, "count_wrap");
    IN_SD[0] = 1'b0;
    repeat (4) @(negedge CLK);
    read_cycle(12'h245, 16'h0001, 1'b1, 8'h01, 8'h00, "count_snap");
    read_cycle(12'h245, 16'h0002, 1'b1, 8'h00, 8'h00, "count_after");

    // 5: address decode and mode readback
    read_cycle(12'h246, 16'h0000, 1'b0, 8'h00, 8'h00, "miss_246");
    read_cycle(12'h340, 16'h0000, 1'b0, 8'h00, 8'h00, "miss_340");
    read_cycle(12'h241, 16'h0000, 1'b0, 8'h00, 8'h00, "miss_241");
    MODE_RB = 3'b101;
    read_cycle(12'h240, 16'h0005, 1'b1, 8'h00, 8'h00, "mode_rb");

    // 6: reset during DRIVE aborts the read and wipes sticky/count
    IN_SD = 8'h00;
    repeat (4) @(negedge CLK);
    SA = 12'h245; IOR = 1'b0;
    repeat (4) @(negedge CLK);
    check("abort_pre_oe", 16'(SD_OE), 16'h0001);
    check("abort_pre_data", SD_OUT, 16'h0002);
    RST = 1'b1;
    @(negedge CLK);
    check("abort_oe", 16'(SD_OE), 16'h0000);
    check("abort_out", SD_OUT, 16'h0000);
    RST = 1'b0;
    repeat (6) @(negedge CLK);
    check("abort_no_refire", 16'(SD_OE), 16'h0000);
    IOR = 1'b1;
    repeat (4) @(negedge CLK);
    read_cycle(12'h244, 16'h0000, 1'b1, 8'h00, 8'h00, "post_rst_sticky");
    read_cycle(12'h245, 16'h0000, 1'b1, 8'h00, 8'h00, "post_rst_count");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
